axi_write_arbiter: RTL and testbench
====================================

Name: axi_write_arbiter

Overview:
- Control-path scheduler that shares the single downstream write path of axi_interconnect among S_COUNT upstream requesters.
- Grants one requester round-robin and holds the grant across AW, the full W burst and the B response, then releases it.
- Single outstanding write. Handshake/control signals only; the interconnect muxes payload (addr, data, id, strb, user) using grant_idx.
- A response watchdog recovers from a downstream slave that never returns B.

Parameters:
- S_COUNT, 4, number of upstream requesters (2..16)
- TIMEOUT, 1024, cycles allowed in RESP before abort (>=2)
- IDX_W, $clog2(S_COUNT), width of grant_idx (derived, not overridden)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- req_awvalid  in  S_COUNT  per-requester AW valid
- req_awready  out  S_COUNT  per-requester AW ready
- req_wvalid  in  S_COUNT  per-requester W valid
- req_wlast  in  S_COUNT  per-requester W last
- req_wready  out  S_COUNT  per-requester W ready
- req_bvalid  out  S_COUNT  per-requester B valid
- req_bready  in  S_COUNT  per-requester B ready
- m_awvalid  out  1  downstream AW valid
- m_awready  in  1  downstream AW ready
- m_wvalid  out  1  downstream W valid
- m_wlast  out  1  downstream W last
- m_wready  in  1  downstream W ready
- m_bvalid  in  1  downstream B valid
- m_bready  out  1  downstream B ready
- grant_active  out  1  a grant is held (state != IDLE)
- grant_idx  out  IDX_W  index of the granted requester, for payload muxing
- grant_onehot  out  S_COUNT  one-hot grant, all zero in IDLE
- timeout_err  out  1  sticky; set on watchdog abort
- err_clr  in  1  synchronous clear of timeout_err

Behaviour:
- Reset: state=IDLE, last_grant=S_COUNT-1 (requester 0 wins first), drain=0, timeout_err=0, wd_cnt=0. All outputs 0.
- Non-granted requesters always see awready=0, wready=0, bvalid=0.
- IDLE:
  - Selection: the first set bit of req_awvalid searched from last_grant+1 with wrap. Register g and go to ADDR.
  - Latency: awvalid to m_awvalid is exactly 1 cycle.
  - m_bready=drain; all other outputs 0.
- ADDR: m_awvalid=req_awvalid[g]; req_awready[g]=m_awready. On m_awvalid&m_awready go to DATA.
- DATA:
  - m_wvalid=req_wvalid[g]; m_wlast=req_wlast[g]; req_wready[g]=m_wready.
  - On a handshake with wlast=1 go to RESP; other beats stay in DATA. Burst length is not checked.
- RESP:
  - req_bvalid[g]=m_bvalid&~drain; m_bready=drain | req_bready[g].
  - Forwarded B handshake: last_grant<=g, go to IDLE.
  - wd_cnt clears on entry and increments each RESP cycle.
  - If wd_cnt==TIMEOUT-1 with no handshake that cycle: set timeout_err and drain, last_grant<=g, go to IDLE. The requester receives no B and must recover at system level.
- drain:
  - While drain=1, the next m_bvalid handshake is absorbed and not forwarded, then drain clears.
  - A new grant may proceed. Its RESP absorbs the stale B first, then forwards the next B.
- Simultaneous err_clr and a new timeout: the set wins.
- Early W: W arriving before its AW is stalled (wready=0) until DATA. AW-to-W ordering is not required of masters.
- No preemption: requests arriving mid-transaction wait. Fairness bound: a requester waits at most S_COUNT-1 complete transactions.
- Async reset mid-burst: everything returns to reset values immediately, no output glitch guarantees beyond that. The downstream slave must be reset together with the arbiter.

Decomposition:
- Package axi_arb_pkg:
  - state enum {IDLE, ADDR, DATA, RESP} (2 bits)
  - function clog2_min1 (returns >=1 for S_COUNT=1 safety)
  - default TIMEOUT constant
- Sub-module arb_rr_select: combinational round-robin priority select.
  - Inputs: req vector, last_grant.
  - Outputs: any, idx, onehot.
  - Reused later for the read-address arbiter.
- The FSM, watchdog and drain logic stay in axi_write_arbiter.

Test Plan:
- Single request: req_awvalid=0010, 4-beat burst, m_*ready=1 → m_awvalid 1 cycle later; grant_idx=1 held; 4 W beats forwarded; req_bvalid[1] pulses; grant_active falls the cycle after B.
- Contention: all four awvalid held high, single-beat bursts → grant order 0,1,2,3,0; no requester starved.
- Backpressure: m_wready toggles 1010…, 8-beat burst from requester 2 → exactly 8 forwarded beats; req_wready[2] mirrors m_wready; other wready stay 0.
- Timeout, TIMEOUT=16, m_bvalid held 0 → IDLE 16 cycles after entering RESP; timeout_err=1.
  - Then m_bvalid=1 → absorbed (m_bready=1, no req_bvalid).
  - Next transaction's B is forwarded normally.
  - err_clr clears the flag.
- Reset mid-DATA: rst low during beat 3 → all outputs 0 asynchronously. After release, requester 0 wins first arbitration.

Source files
------------

// File: rtl/axi_arb_pkg.sv
// Shared types and helpers for the AXI write-path arbiter and its round-robin selector.
package axi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } arb_state_e;

  localparam int DEFAULT_TIMEOUT = 1024;

  // Never returns 0, so a single-requester build still gets a 1-bit index.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/arb_rr_select.sv
// Combinational round-robin pick: first asserted request strictly after last_grant, with wrap.
module arb_rr_select
  import axi_arb_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = clog2_min1(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_grant_i,
  output logic          any_o,
  output logic [IW-1:0] idx_o,
  output logic [N-1:0]  onehot_o
);

  logic [IW-1:0] cand;

  always_comb begin
    any_o    = 1'b0;
    idx_o    = '0;
    onehot_o = '0;
    cand     = '0;
    // Walk from the farthest candidate to the nearest so the nearest hit wins.
    for (int k = N; k >= 1; k--) begin
      cand = IW'((int'(last_grant_i) + k) % N);
      if (req_i[cand]) begin
        any_o = 1'b1;
        idx_o = cand;
      end
    end
    onehot_o[idx_o] = any_o;
  end

endmodule

// File: rtl/axi_write_arbiter.sv
// Shares one downstream AXI write path among S_COUNT requesters; one outstanding write,
// grant held from AW through B, with a response watchdog and stale-B drain.
module axi_write_arbiter
  import axi_arb_pkg::*;
#(
  parameter  int S_COUNT = 4,
  parameter  int TIMEOUT = DEFAULT_TIMEOUT,
  localparam int IDX_W   = clog2_min1(S_COUNT)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [S_COUNT-1:0] req_awvalid,
  output logic [S_COUNT-1:0] req_awready,
  input  logic [S_COUNT-1:0] req_wvalid,
  input  logic [S_COUNT-1:0] req_wlast,
  output logic [S_COUNT-1:0] req_wready,
  output logic [S_COUNT-1:0] req_bvalid,
  input  logic [S_COUNT-1:0] req_bready,
  output logic               m_awvalid,
  input  logic               m_awready,
  output logic               m_wvalid,
  output logic               m_wlast,
  input  logic               m_wready,
  input  logic               m_bvalid,
  output logic               m_bready,
  output logic               grant_active,
  output logic [IDX_W-1:0]   grant_idx,
  output logic [S_COUNT-1:0] grant_onehot,
  output logic               timeout_err,
  input  logic               err_clr
);

  localparam int                WD_W     = clog2_min1(TIMEOUT);
  localparam logic [IDX_W-1:0]  LAST_RST = IDX_W'(S_COUNT - 1);
  localparam logic [WD_W-1:0]   WD_MAX   = WD_W'(TIMEOUT - 1);

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   g_q, g_d;
  logic [S_COUNT-1:0] oh_q, oh_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic               drain_q, drain_d;
  logic               terr_q, terr_d;
  logic [WD_W-1:0]    wd_q, wd_d;

  logic               sel_any;
  logic [IDX_W-1:0]   sel_idx;
  logic [S_COUNT-1:0] sel_oh;

  // Ready/valid destined for the granted requester only; fanned out by oh_q below.
  logic               aw_rdy;
  logic               w_rdy;
  logic               b_vld;

  arb_rr_select #(.N(S_COUNT)) u_sel (
    .req_i        (req_awvalid),
    .last_grant_i (last_q),
    .any_o        (sel_any),
    .idx_o        (sel_idx),
    .onehot_o     (sel_oh)
  );

  always_comb begin
    state_d   = state_q;
    g_d       = g_q;
    oh_d      = oh_q;
    last_d    = last_q;
    drain_d   = drain_q;
    terr_d    = terr_q & ~err_clr;
    wd_d      = wd_q;
    m_awvalid = 1'b0;
    m_wvalid  = 1'b0;
    m_wlast   = 1'b0;
    m_bready  = 1'b0;
    aw_rdy    = 1'b0;
    w_rdy     = 1'b0;
    b_vld     = 1'b0;

    case (state_q)
      IDLE: begin
        m_bready = drain_q;
        if (drain_q && m_bvalid) drain_d = 1'b0;
        if (sel_any) begin
          g_d     = sel_idx;
          oh_d    = sel_oh;
          state_d = ADDR;
        end
      end
      ADDR: begin
        m_awvalid = req_awvalid[g_q];
        aw_rdy    = m_awready;
        if (m_awvalid && m_awready) state_d = DATA;
      end
      DATA: begin
        m_wvalid = req_wvalid[g_q];
        m_wlast  = req_wlast[g_q];
        w_rdy    = m_wready;
        if (m_wvalid && m_wready && m_wlast) begin
          wd_d    = '0;
          state_d = RESP;
        end
      end
      RESP: begin
        // A pending drain swallows the first B (stale, from an aborted write).
        b_vld    = m_bvalid & ~drain_q;
        m_bready = drain_q | req_bready[g_q];
        wd_d     = wd_q + 1'b1;
        if (m_bvalid && drain_q) drain_d = 1'b0;
        if (b_vld && req_bready[g_q]) begin
          last_d  = g_q;
          state_d = IDLE;
        end else if (wd_q == WD_MAX) begin
          terr_d  = 1'b1;
          drain_d = 1'b1;
          last_d  = g_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      g_q     <= '0;
      oh_q    <= '0;
      last_q  <= LAST_RST;
      drain_q <= 1'b0;
      terr_q  <= 1'b0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      oh_q    <= oh_d;
      last_q  <= last_d;
      drain_q <= drain_d;
      terr_q  <= terr_d;
      wd_q    <= wd_d;
    end
  end

  assign grant_active = (state_q != IDLE);
  assign grant_idx    = grant_active ? g_q : '0;
  assign grant_onehot = grant_active ? oh_q : '0;
  assign timeout_err  = terr_q;

  for (genvar gi = 0; gi < S_COUNT; gi++) begin : g_req
    assign req_awready[gi] = oh_q[gi] & aw_rdy;
    assign req_wready[gi]  = oh_q[gi] & w_rdy;
    assign req_bvalid[gi]  = oh_q[gi] & b_vld;
  end

endmodule

// File: tb/tb_axi_write_arbiter.sv
// Directed bench for axi_write_arbiter: 4 requesters, short watchdog (16 cycles).
module tb_axi_write_arbiter;

  localparam int S  = 4;
  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [S-1:0] req_awvalid, req_awready, req_wvalid, req_wlast, req_wready;
  logic [S-1:0] req_bvalid, req_bready;
  logic         m_awvalid, m_awready, m_wvalid, m_wlast, m_wready, m_bvalid, m_bready;
  logic         grant_active;
  logic [1:0]   grant_idx;
  logic [S-1:0] grant_onehot;
  logic         timeout_err, err_clr;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  axi_write_arbiter #(.S_COUNT(S), .TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_awvalid  (req_awvalid),
    .req_awready  (req_awready),
    .req_wvalid   (req_wvalid),
    .req_wlast    (req_wlast),
    .req_wready   (req_wready),
    .req_bvalid   (req_bvalid),
    .req_bready   (req_bready),
    .m_awvalid    (m_awvalid),
    .m_awready    (m_awready),
    .m_wvalid     (m_wvalid),
    .m_wlast      (m_wlast),
    .m_wready     (m_wready),
    .m_bvalid     (m_bvalid),
    .m_bready     (m_bready),
    .grant_active (grant_active),
    .grant_idx    (grant_idx),
    .grant_onehot (grant_onehot),
    .timeout_err  (timeout_err),
    .err_clr      (err_clr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    req_awvalid = '0;
    req_wvalid  = '0;
    req_wlast   = '0;
    req_bready  = '0;
    m_awready   = 1'b0;
    m_wready    = 1'b0;
    m_bvalid    = 1'b0;
    err_clr     = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    idle_inputs();
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic wait_active(input logic level, input int budget, output int cycles);
    cycles = 0;
    while (grant_active !== level && cycles < budget) begin
      tick();
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst         = 1'b0;
    req_awvalid = 4'b1111;
    req_wvalid  = 4'b1111;
    req_wlast   = 4'b1111;
    req_bready  = 4'b1111;
    m_awready   = 1'b1;
    m_wready    = 1'b1;
    m_bvalid    = 1'b1;
    err_clr     = 1'b0;
    tick();
    n_assert++;
    if (grant_active !== 1'b0 || grant_idx !== 2'd0 || grant_onehot !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_grant: active=%b idx=%0d onehot=%b, expected 0/0/0000",
               grant_active, grant_idx, grant_onehot);
    end
    n_assert++;
    if (m_awvalid !== 1'b0 || m_wvalid !== 1'b0 || m_wlast !== 1'b0 || m_bready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_master: aw=%b w=%b wlast=%b bready=%b, expected all 0",
               m_awvalid, m_wvalid, m_wlast, m_bready);
    end
    n_assert++;
    if (req_awready !== 4'b0 || req_wready !== 4'b0 || req_bvalid !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_req: awready=%b wready=%b bvalid=%b, expected 0000",
               req_awready, req_wready, req_bvalid);
    end
    n_assert++;
    if (timeout_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_err: timeout_err=%b, expected 0", timeout_err);
    end
    idle_inputs();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_single_request();
    int beats;
    logic exp_last;
    req_bready  = 4'b1111;
    m_awready   = 1'b1;
    m_wready    = 1'b1;
    req_awvalid = 4'b0010;
    settle();
    n_assert++;
    if (m_awvalid !== 1'b0 || grant_active !== 1'b0) begin
      n_fail++;
      $display("FAIL single_idle: m_awvalid=%b active=%b, expected 0/0", m_awvalid, grant_active);
    end
    tick();
    n_assert++;
    if (m_awvalid !== 1'b1 || grant_idx !== 2'd1 || grant_onehot !== 4'b0010 ||
        req_awready !== 4'b0010) begin
      n_fail++;
      $display("FAIL single_addr: m_awvalid=%b idx=%0d onehot=%b awready=%b, expected 1/1/0010/0010",
               m_awvalid, grant_idx, grant_onehot, req_awready);
    end
    tick();
    req_awvalid = 4'b0000;
    req_wvalid  = 4'b0010;
    beats = 0;
    for (int b = 0; b < 4; b++) begin
      exp_last  = (b == 3);
      req_wlast = exp_last ? 4'b0010 : 4'b0000;
      settle();
      if (m_wvalid === 1'b1 && m_wready === 1'b1) beats++;
      n_assert++;
      if (req_wready !== 4'b0010 || grant_idx !== 2'd1 || m_wlast !== exp_last) begin
        n_fail++;
        $display("FAIL single_beat%0d: wready=%b idx=%0d wlast=%b, expected 0010/1/%b",
                 b, req_wready, grant_idx, m_wlast, exp_last);
      end
      tick();
    end
    req_wvalid = 4'b0000;
    req_wlast  = 4'b0000;
    settle();
    n_assert++;
    if (beats !== 4) begin
      n_fail++;
      $display("FAIL single_beats: forwarded=%0d, expected 4", beats);
    end
    n_assert++;
    if (grant_active !== 1'b1 || m_bready !== 1'b1 || req_bvalid !== 4'b0000) begin
      n_fail++;
      $display("FAIL single_resp_wait: active=%b bready=%b bvalid=%b, expected 1/1/0000",
               grant_active, m_bready, req_bvalid);
    end
    m_bvalid = 1'b1;
    settle();
    n_assert++;
    if (req_bvalid !== 4'b0010) begin
      n_fail++;
      $display("FAIL single_bvalid: req_bvalid=%b, expected 0010", req_bvalid);
    end
    tick();
    m_bvalid = 1'b0;
    settle();
    n_assert++;
    if (grant_active !== 1'b0 || req_bvalid !== 4'b0000 || m_bready !== 1'b0) begin
      n_fail++;
      $display("FAIL single_release: active=%b bvalid=%b bready=%b, expected 0/0000/0",
               grant_active, req_bvalid, m_bready);
    end
  endtask

  task automatic test_contention();
    logic [1:0] exp_order [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    int cyc;
    apply_reset();
    m_awready   = 1'b1;
    m_wready    = 1'b1;
    m_bvalid    = 1'b1;
    req_bready  = 4'b1111;
    req_awvalid = 4'b1111;
    req_wvalid  = 4'b1111;
    req_wlast   = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_active(1'b1, 8, cyc);
      n_assert++;
      if (grant_active !== 1'b1 || grant_idx !== exp_order[i]) begin
        n_fail++;
        $display("FAIL contention_grant%0d: active=%b idx=%0d, expected 1/%0d",
                 i, grant_active, grant_idx, exp_order[i]);
      end
      wait_active(1'b0, 8, cyc);
      n_assert++;
      if (grant_active !== 1'b0 || cyc !== 3) begin
        n_fail++;
        $display("FAIL contention_len%0d: active=%b cycles=%0d, expected 0/3", i, grant_active, cyc);
      end
    end
    idle_inputs();
  endtask

  task automatic test_backpressure();
    int beats;
    int cyc;
    m_awready   = 1'b1;
    req_bready  = 4'b1111;
    req_awvalid = 4'b0100;
    wait_active(1'b1, 4, cyc);
    n_assert++;
    if (grant_idx !== 2'd2) begin
      n_fail++;
      $display("FAIL bp_grant: idx=%0d, expected 2", grant_idx);
    end
    tick();
    req_awvalid = 4'b0000;
    req_wvalid  = 4'b0100;
    beats = 0;
    cyc   = 0;
    while (beats < 8 && cyc < 40) begin
      m_wready  = (cyc % 2 == 0);
      req_wlast = (beats == 7) ? 4'b0100 : 4'b0000;
      cyc++;
      settle();
      n_assert++;
      if (req_wready !== (m_wready ? 4'b0100 : 4'b0000)) begin
        n_fail++;
        $display("FAIL bp_wready_mirror: wready=%b m_wready=%b, expected 0%b00",
                 req_wready, m_wready, m_wready);
      end
      if (m_wvalid === 1'b1 && m_wready === 1'b1) beats++;
      tick();
    end
    n_assert++;
    if (beats !== 8) begin
      n_fail++;
      $display("FAIL bp_beats: forwarded=%0d, expected 8", beats);
    end
    req_wlast = 4'b0000;
    m_wready  = 1'b1;
    settle();
    n_assert++;
    if (m_wvalid !== 1'b0 || req_wready !== 4'b0000 || grant_active !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_after_last: m_wvalid=%b wready=%b active=%b, expected 0/0000/1",
               m_wvalid, req_wready, grant_active);
    end
    m_bvalid = 1'b1;
    tick();
    m_bvalid   = 1'b0;
    req_wvalid = 4'b0000;
    settle();
    n_assert++;
    if (grant_active !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release: active=%b, expected 0", grant_active);
    end
    idle_inputs();
  endtask

  task automatic test_timeout();
    int cyc;
    int k;
    m_awready   = 1'b1;
    m_wready    = 1'b1;
    req_bready  = 4'b1111;
    req_awvalid = 4'b1000;
    wait_active(1'b1, 4, cyc);
    n_assert++;
    if (grant_idx !== 2'd3) begin
      n_fail++;
      $display("FAIL to_grant: idx=%0d, expected 3", grant_idx);
    end
    tick();
    req_awvalid = 4'b0000;
    req_wvalid  = 4'b1000;
    req_wlast   = 4'b1000;
    tick();
    req_wvalid = 4'b0000;
    req_wlast  = 4'b0000;
    k = 0;
    while (grant_active === 1'b1 && k < 40) begin
      tick();
      k++;
    end
    n_assert++;
    if (k !== TO || timeout_err !== 1'b1) begin
      n_fail++;
      $display("FAIL to_abort: resp_cycles=%0d timeout_err=%b, expected %0d/1", k, timeout_err, TO);
    end
    n_assert++;
    if (m_bready !== 1'b1) begin
      n_fail++;
      $display("FAIL to_drain_ready: m_bready=%b, expected 1", m_bready);
    end
    m_bvalid = 1'b1;
    settle();
    n_assert++;
    if (req_bvalid !== 4'b0000) begin
      n_fail++;
      $display("FAIL to_absorb: req_bvalid=%b, expected 0000", req_bvalid);
    end
    tick();
    m_bvalid = 1'b0;
    settle();
    n_assert++;
    if (m_bready !== 1'b0 || timeout_err !== 1'b1) begin
      n_fail++;
      $display("FAIL to_drained: m_bready=%b timeout_err=%b, expected 0/1", m_bready, timeout_err);
    end
    req_awvalid = 4'b0010;
    wait_active(1'b1, 4, cyc);
    tick();
    req_awvalid = 4'b0000;
    req_wvalid  = 4'b0010;
    req_wlast   = 4'b0010;
    tick();
    req_wvalid = 4'b0000;
    req_wlast  = 4'b0000;
    m_bvalid   = 1'b1;
    settle();
    n_assert++;
    if (req_bvalid !== 4'b0010) begin
      n_fail++;
      $display("FAIL to_next_b: req_bvalid=%b, expected 0010", req_bvalid);
    end
    tick();
    m_bvalid = 1'b0;
    err_clr  = 1'b1;
    tick();
    err_clr = 1'b0;
    settle();
    n_assert++;
    if (timeout_err !== 1'b0 || grant_active !== 1'b0) begin
      n_fail++;
      $display("FAIL to_err_clr: timeout_err=%b active=%b, expected 0/0", timeout_err, grant_active);
    end
    idle_inputs();
  endtask

  task automatic test_drain_in_resp();
    int cyc;
    int k;
    m_awready   = 1'b1;
    m_wready    = 1'b1;
    req_awvalid = 4'b0001;
    wait_active(1'b1, 4, cyc);
    n_assert++;
    if (grant_idx !== 2'd0) begin
      n_fail++;
      $display("FAIL dr_grant0: idx=%0d, expected 0", grant_idx);
    end
    tick();
    req_awvalid = 4'b0000;
    req_wvalid  = 4'b0001;
    req_wlast   = 4'b0001;
    tick();
    req_wvalid = 4'b0000;
    req_wlast  = 4'b0000;
    err_clr    = 1'b1;
    k = 0;
    while (grant_active === 1'b1 && k < 40) begin
      tick();
      k++;
    end
    err_clr = 1'b0;
    settle();
    n_assert++;
    if (k !== TO || timeout_err !== 1'b1) begin
      n_fail++;
      $display("FAIL dr_set_wins: resp_cycles=%0d timeout_err=%b, expected %0d/1", k, timeout_err, TO);
    end
    req_awvalid = 4'b0100;
    wait_active(1'b1, 4, cyc);
    tick();
    req_awvalid = 4'b0000;
    req_wvalid  = 4'b0100;
    req_wlast   = 4'b0100;
    tick();
    req_wvalid = 4'b0000;
    req_wlast  = 4'b0000;
    m_bvalid   = 1'b1;
    settle();
    n_assert++;
    if (req_bvalid !== 4'b0000 || m_bready !== 1'b1 || grant_idx !== 2'd2) begin
      n_fail++;
      $display("FAIL dr_stale: bvalid=%b bready=%b idx=%0d, expected 0000/1/2",
               req_bvalid, m_bready, grant_idx);
    end
    tick();
    n_assert++;
    if (req_bvalid !== 4'b0100 || m_bready !== 1'b0 || grant_active !== 1'b1) begin
      n_fail++;
      $display("FAIL dr_forward: bvalid=%b bready=%b active=%b, expected 0100/0/1",
               req_bvalid, m_bready, grant_active);
    end
    req_bready = 4'b0100;
    tick();
    m_bvalid = 1'b0;
    settle();
    n_assert++;
    if (grant_active !== 1'b0) begin
      n_fail++;
      $display("FAIL dr_release: active=%b, expected 0", grant_active);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_data();
    int cyc;
    m_awready   = 1'b1;
    m_wready    = 1'b1;
    req_awvalid = 4'b0010;
    wait_active(1'b1, 4, cyc);
    tick();
    req_awvalid = 4'b0000;
    req_wvalid  = 4'b0010;
    tick();
    tick();
    settle();
    n_assert++;
    if (m_wvalid !== 1'b1 || req_wready !== 4'b0010) begin
      n_fail++;
      $display("FAIL rst_pre_data: m_wvalid=%b wready=%b, expected 1/0010", m_wvalid, req_wready);
    end
    rst = 1'b0;
    #1;
    n_assert++;
    if (grant_active !== 1'b0 || m_wvalid !== 1'b0 || req_wready !== 4'b0000 ||
        grant_onehot !== 4'b0000 || grant_idx !== 2'd0 || m_bready !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_async: active=%b m_wvalid=%b wready=%b onehot=%b idx=%0d bready=%b, expected all 0",
               grant_active, m_wvalid, req_wready, grant_onehot, grant_idx, m_bready);
    end
    idle_inputs();
    tick();
    rst = 1'b1;
    req_awvalid = 4'b1111;
    tick();
    n_assert++;
    if (grant_active !== 1'b1 || grant_idx !== 2'd0) begin
      n_fail++;
      $display("FAIL rst_first_winner: active=%b idx=%0d, expected 1/0", grant_active, grant_idx);
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_request();
    test_contention();
    test_backpressure();
    test_timeout();
    test_drain_in_resp();
    test_reset_mid_data();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
